prog_counter: RTL and testbench
===============================

Name: prog_counter

Overview:
- Fetch-stage program counter that drives the instruction-memory address each cycle.
- It consumes the D-bit jump/branch target from the branch-target lookup table and applies it as an absolute or PC-relative (wrap-around) redirect.
- It adds a small call/return stack, a run/done state machine and a run-cycle counter for program timing.

Parameters:
- D, 10, PC width in bits; all PC arithmetic is modulo 2^D.
- STACK_DEPTH, 4, number of return-address entries (power of 2, >=2).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  1-cycle pulse; (re)starts the program at address 0.
- stall  input  1  hold PC and stack this cycle (RUN only).
- halt_in  input  1  program-end request from decode.
- jump_en  input  1  instruction is a jump/branch.
- branch_taken  input  1  branch condition true; redirect only if jump_en & branch_taken.
- jump_rel  input  1  1: next = pc + target (two's complement, mod 2^D); 0: next = target.
- call_en  input  1  call: push pc+1, next = target (always absolute).
- ret_en  input  1  return: next = popped address.
- target  input  D  redirect target from the branch-target LUT.
- prog_ctr  output  D  current fetch address.
- done  output  1  high while in DONE.
- stack_ovf  output  1  sticky: call attempted with stack full.
- stack_unf  output  1  sticky: return attempted with stack empty.
- cycle_ct  output  16  RUN cycles since last start, saturating at 16'hFFFF.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, prog_ctr=0, done=0, stack pointer=0 (empty).
  - stack_ovf=0, stack_unf=0, cycle_ct=0.
  - Reset asserted mid-RUN abandons the program immediately.
- States: IDLE, RUN, DONE.
- start=1 in any state, sampled at the clock edge:
  - next state=RUN, prog_ctr=0, stack emptied.
  - Sticky flags cleared, cycle_ct=0.
  - start overrides every other input that cycle.
- IDLE: all inputs except start are ignored; prog_ctr holds 0.
- RUN:
  - cycle_ct increments every cycle, including stalled cycles, and saturates at 16'hFFFF.
  - If stall=1, prog_ctr and the stack hold and control inputs are ignored, including halt_in.
  - If stall=0, the first matching rule below applies (fixed priority):
    1. halt_in: next state=DONE; prog_ctr holds; no stack change.
    2. ret_en, stack non-empty: prog_ctr = top entry; pop.
    3. ret_en, stack empty: stack_unf=1; prog_ctr = prog_ctr+1.
    4. call_en, stack not full: push (prog_ctr+1) mod 2^D; prog_ctr = target.
    5. call_en, stack full: stack_ovf=1; no push (the oldest entries are kept); prog_ctr = target.
    6. jump_en & branch_taken: prog_ctr = jump_rel ? (prog_ctr+target) mod 2^D : target.
    7. Otherwise: prog_ctr = (prog_ctr+1) mod 2^D.
- Arithmetic:
  - target is treated as a D-bit two's-complement value only in relative mode.
  - The sum is truncated to D bits (e.g. D=10: 4 + 1023 → 3).
  - The increment wraps 2^D-1 → 0 with no flag.
- Latency: the redirect takes effect on the next edge, so the new prog_ctr is visible 1 cycle after the inputs are sampled. There are no delay slots inside this block.
- DONE:
  - done=1; prog_ctr frozen; cycle_ct frozen.
  - Only start (→ RUN) or reset (→ IDLE) leave DONE.
- Sticky flags hold until the next start or reset; they do not stop execution.

Test Plan:
- Reset, start pulse, 5 idle RUN cycles → prog_ctr 0,1,2,3,4,5; cycle_ct=5; done=0.
- At pc=4: jump_en=1, branch_taken=1, jump_rel=1, target=10'h3FF → pc=3. Next cycle, absolute target=41 → pc=41. branch_taken=0 at pc=41 → pc=42.
- call target=99 at pc=11 → pc=99; ret → pc=12. Five nested calls with depth 4 → 5th call sets stack_ovf and pc=target; then 4 rets return correctly and a 5th ret sets stack_unf with pc+1.
- stall held 3 cycles during call_en at pc=7 → pc stays 7 and no push; cycle_ct advances by 3; release → call executes.
- halt_in at pc=20 together with ret_en → done=1 and pc=20 (halt wins); start → pc=0, flags cleared, done=0. Run from pc=1023 incrementing → wraps to 0.
- reset_n asserted asynchronously mid-cycle in RUN at pc=57 → outputs 0 immediately, state IDLE; inputs ignored until start.

Source files
------------

// File: rtl/prog_counter.sv
// Fetch-stage PC with absolute/relative redirect, call/return stack,
// IDLE/RUN/DONE control and a saturating RUN-cycle counter.
// Ports:
//   clk, reset_n (async, active-low)
//   start, stall, halt_in, jump_en, branch_taken, jump_rel,
//   call_en, ret_en, target[D]
//   prog_ctr[D], done, stack_ovf, stack_unf, cycle_ct[16]
module prog_counter #(
  parameter int D           = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         stall,
  input  logic         halt_in,
  input  logic         jump_en,
  input  logic         branch_taken,
  input  logic         jump_rel,
  input  logic         call_en,
  input  logic         ret_en,
  input  logic [D-1:0] target,
  output logic [D-1:0] prog_ctr,
  output logic         done,
  output logic         stack_ovf,
  output logic         stack_unf,
  output logic [15:0]  cycle_ct
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam logic [AW:0]   FULL  = (AW+1)'(STACK_DEPTH);
  localparam logic [AW:0]   ONE_S = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_A = AW'(1);
  localparam logic [D-1:0]  ONE_D = D'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [D-1:0] stack [STACK_DEPTH];
  logic [AW:0]   sp;
  logic [AW-1:0] top;
  logic          empty;
  logic          full;
  logic          active;
  logic [D-1:0]  pc_inc;
  logic [D-1:0]  pc_nxt;
  logic          push;
  logic          pop;
  logic          set_ovf;
  logic          set_unf;

  // start wins over everything, so it masks the RUN datapath.
  assign active = (state == RUN) && !stall && !start;
  assign empty  = (sp == '0);
  assign full   = (sp == FULL);
  assign top    = sp[AW-1:0] - ONE_A;
  assign pc_inc = prog_ctr + ONE_D;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start)
      state_nxt = RUN;
    else if (active && halt_in)
      state_nxt = DONE;
  end

  always_comb begin
    done = (state == DONE);
  end

  always_comb begin
    pc_nxt  = prog_ctr;
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (active) begin
      if (halt_in) begin
        pc_nxt = prog_ctr;
      end else if (ret_en && !empty) begin
        pc_nxt = stack[top];
        pop    = 1'b1;
      end else if (ret_en) begin
        set_unf = 1'b1;
        pc_nxt  = pc_inc;
      end else if (call_en) begin
        push    = !full;
        set_ovf = full;
        pc_nxt  = target;
      end else if (jump_en && branch_taken) begin
        pc_nxt = jump_rel ? prog_ctr + target
                          : target;
      end else begin
        pc_nxt = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prog_ctr  <= '0;
      sp        <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
      cycle_ct  <= '0;
    end else if (start) begin
      prog_ctr  <= '0;
      sp        <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
      cycle_ct  <= '0;
    end else begin
      prog_ctr <= pc_nxt;
      if (push)     sp <= sp + ONE_S;
      else if (pop) sp <= sp - ONE_S;
      if (set_ovf) stack_ovf <= 1'b1;
      if (set_unf) stack_unf <= 1'b1;
      if (state == RUN && cycle_ct != 16'hFFFF)
        cycle_ct <= cycle_ct + 16'd1;
    end
  end

  // Return-address storage needs no reset: it is only read when sp > 0.
  always_ff @(posedge clk) begin
    if (push) stack[sp[AW-1:0]] <= pc_inc;
  end

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter: directed scenario plus random run,
// checked against a queue-based reference model.
module tb_prog_counter;

  localparam int D     = 10;
  localparam int N     = 1 << D;
  localparam int DEPTH = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         stall = 1'b0;
  logic         halt_in = 1'b0;
  logic         jump_en = 1'b0;
  logic         branch_taken = 1'b0;
  logic         jump_rel = 1'b0;
  logic         call_en = 1'b0;
  logic         ret_en = 1'b0;
  logic [D-1:0] target = '0;
  logic [D-1:0] prog_ctr;
  logic         done;
  logic         stack_ovf;
  logic         stack_unf;
  logic [15:0]  cycle_ct;

  prog_counter #(.D(D), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .stall(stall),
    .halt_in(halt_in),
    .jump_en(jump_en),
    .branch_taken(branch_taken),
    .jump_rel(jump_rel),
    .call_en(call_en),
    .ret_en(ret_en),
    .target(target),
    .prog_ctr(prog_ctr),
    .done(done),
    .stack_ovf(stack_ovf),
    .stack_unf(stack_unf),
    .cycle_ct(cycle_ct)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  int m_st;
  int m_pc;
  int m_ovf;
  int m_unf;
  int m_cyc;
  int m_stk[$];

  function automatic int wrap(input int v);
    return ((v % N) + N) % N;
  endfunction

  function automatic int sext(input int v);
    return (v >= N / 2) ? v - N : v;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st  = M_IDLE;
    m_pc  = 0;
    m_ovf = 0;
    m_unf = 0;
    m_cyc = 0;
    m_stk.delete();
  endtask

  task automatic model_step(input bit s, st, h, je, bt, jr, ce, re,
                            input int t);
    if (s) begin
      m_st  = M_RUN;
      m_pc  = 0;
      m_ovf = 0;
      m_unf = 0;
      m_cyc = 0;
      m_stk.delete();
    end else if (m_st == M_RUN) begin
      if (m_cyc < 65535) m_cyc++;
      if (!st) begin
        if (h) begin
          m_st = M_DONE;
        end else if (re) begin
          if (m_stk.size() > 0) begin
            m_pc = m_stk.pop_back();
          end else begin
            m_unf = 1;
            m_pc  = wrap(m_pc + 1);
          end
        end else if (ce) begin
          if (m_stk.size() < DEPTH) m_stk.push_back(wrap(m_pc + 1));
          else m_ovf = 1;
          m_pc = t;
        end else if (je && bt) begin
          m_pc = jr ? wrap(m_pc + sext(t)) : t;
        end else begin
          m_pc = wrap(m_pc + 1);
        end
      end
    end
  endtask

  task automatic check_all();
    chk("prog_ctr", 32'(prog_ctr), 32'(m_pc));
    chk("done", 32'(done), 32'(m_st == M_DONE));
    chk("stack_ovf", 32'(stack_ovf), 32'(m_ovf));
    chk("stack_unf", 32'(stack_unf), 32'(m_unf));
    chk("cycle_ct", 32'(cycle_ct), 32'(m_cyc));
  endtask

  task automatic cyc(input bit s, st, h, je, bt, jr, ce, re,
                     input int t);
    @(negedge clk);
    start        = s;
    stall        = st;
    halt_in      = h;
    jump_en      = je;
    branch_taken = bt;
    jump_rel     = jr;
    call_en      = ce;
    ret_en       = re;
    target       = D'(t);
    @(posedge clk);
    if (reset_n) model_step(s, st, h, je, bt, jr, ce, re, t);
    #1;
    check_all();
  endtask

  task automatic idle();   cyc(0,0,0,0,0,0,0,0,0); endtask
  task automatic go();     cyc(1,0,0,0,0,0,0,0,0); endtask
  task automatic jmp(input int t); cyc(0,0,0,1,1,0,0,0,t); endtask
  task automatic call(input int t); cyc(0,0,0,0,0,0,1,0,t); endtask
  task automatic ret();    cyc(0,0,0,0,0,0,0,1,0); endtask

  initial begin
    int c0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;

    // start then free-running increments
    go();
    chk("start_pc", 32'(prog_ctr), 32'd0);
    repeat (5) idle();
    chk("run5_pc", 32'(prog_ctr), 32'd5);
    chk("run5_cyc", 32'(cycle_ct), 32'd5);

    // relative wrap, absolute, not-taken branch
    go();
    repeat (4) idle();
    cyc(0,0,0,1,1,1,0,0,10'h3FF);
    chk("rel_neg1", 32'(prog_ctr), 32'd3);
    jmp(41);
    chk("abs41", 32'(prog_ctr), 32'd41);
    cyc(0,0,0,1,0,0,0,0,500);
    chk("not_taken", 32'(prog_ctr), 32'd42);

    // call / return
    jmp(11);
    call(99);
    chk("call99", 32'(prog_ctr), 32'd99);
    ret();
    chk("ret12", 32'(prog_ctr), 32'd12);

    // overflow and underflow
    for (int i = 0; i < 5; i++) call(100 + i);
    chk("ovf_pc", 32'(prog_ctr), 32'd104);
    chk("ovf_flag", 32'(stack_ovf), 32'd1);
    ret();
    chk("ret103", 32'(prog_ctr), 32'd103);
    repeat (3) ret();
    chk("ret13", 32'(prog_ctr), 32'd13);
    ret();
    chk("unf_pc", 32'(prog_ctr), 32'd14);
    chk("unf_flag", 32'(stack_unf), 32'd1);

    // stall during call
    jmp(7);
    c0 = m_cyc;
    repeat (3) cyc(0,1,0,0,0,0,1,0,200);
    chk("stall_pc", 32'(prog_ctr), 32'd7);
    chk("stall_cyc", 32'(cycle_ct), 32'(c0 + 3));
    call(200);
    chk("call200", 32'(prog_ctr), 32'd200);
    ret();
    chk("ret8", 32'(prog_ctr), 32'd8);

    // halt wins over ret, DONE freezes, start recovers
    jmp(20);
    cyc(0,0,1,0,0,0,0,1,0);
    chk("halt_pc", 32'(prog_ctr), 32'd20);
    chk("halt_done", 32'(done), 32'd1);
    c0 = m_cyc;
    jmp(300);
    chk("done_pc", 32'(prog_ctr), 32'd20);
    chk("done_cyc", 32'(cycle_ct), 32'(c0));
    go();
    chk("restart_ovf", 32'(stack_ovf), 32'd0);
    chk("restart_done", 32'(done), 32'd0);

    // increment wrap
    jmp(1023);
    idle();
    chk("wrap0", 32'(prog_ctr), 32'd0);

    // asynchronous reset mid-cycle
    jmp(57);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_pc", 32'(prog_ctr), 32'd0);
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
    jmp(77);
    call(33);
    idle();
    chk("idle_pc", 32'(prog_ctr), 32'd0);
    go();

    // random run
    for (int i = 0; i < 600; i++) begin
      bit s, st, h, je, bt, jr, ce, re;
      int t;
      s  = ($urandom_range(0, 49) == 0) ||
           (m_st != M_RUN && $urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 5) == 0);
      h  = ($urandom_range(0, 39) == 0);
      je = 1'($urandom);
      bt = 1'($urandom);
      jr = 1'($urandom);
      ce = ($urandom_range(0, 4) == 0);
      re = ($urandom_range(0, 4) == 0);
      t  = $urandom_range(0, N - 1);
      cyc(s, st, h, je, bt, jr, ce, re, t);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
